// File: rtl/ips_dbc_trigger_seq_v1_2.sv
// Debug-core trigger sequencer: serial config chain, arm-time shadow copy, multi-level hit sequencer.
// Define IPS_DBC_TRIG_LEVEL_EN for a level trigger; otherwise trigger is a one-cycle pulse.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | not armed, match ignored
// ARMED     | walking levels, counting hits on sel[cur_lvl]
// TRIGGERED | final level completed, held until arm or disarm
module ips_dbc_trigger_seq_v1_2 #(
  parameter int MATCH_NUM = 4,
  parameter int SEQ_LEVEL = 4,
  parameter int CNT_WIDTH = 8,
  localparam int SEL_W     = $clog2(MATCH_NUM),
  localparam int LVL_W     = $clog2(SEQ_LEVEL),
  localparam int CHAIN_LEN = LVL_W + SEQ_LEVEL * (SEL_W + CNT_WIDTH)
) (
  input  logic                 clk_trig,
  input  logic                 h_rstn,
  input  logic [MATCH_NUM-1:0] match,
  input  logic                 conf_sel,
  input  logic                 shift_i,
  input  logic                 conf_tdi,
  output logic                 conf_tdo,
  input  logic                 arm,
  input  logic                 disarm,
  output logic                 trigger,
  output logic [1:0]           seq_state,
  output logic [LVL_W-1:0]     cur_lvl
);

  localparam int FIELD_W = SEL_W + CNT_WIDTH;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2
  } state_t;

  state_t               state;
  logic [CHAIN_LEN-1:0] chain;
  logic [CHAIN_LEN-1:0] shadow;
  logic [CNT_WIDTH-1:0] occ;

  logic [SEL_W-1:0]     cur_sel;
  logic [CNT_WIDTH-1:0] cur_cnt;
  logic [LVL_W-1:0]     last_lvl;
  logic                 hit;
  int                   lvl_base;

  always_ff @(posedge clk_trig or negedge h_rstn) begin
    if (!h_rstn) begin
      chain <= '0;
    end else if (conf_sel && shift_i) begin
      chain <= {conf_tdi, chain[CHAIN_LEN-1:1]};
    end
  end

  assign conf_tdo = chain[0];

  // Level fields always come from the shadow so reshifting never disturbs a running sequence.
  always_comb begin
    lvl_base = int'(cur_lvl) * FIELD_W;
    cur_cnt  = shadow[lvl_base +: CNT_WIDTH];
    cur_sel  = shadow[lvl_base + CNT_WIDTH +: SEL_W];
    last_lvl = shadow[CHAIN_LEN-1 -: LVL_W];
    hit      = match[cur_sel];
  end

  always_ff @(posedge clk_trig or negedge h_rstn) begin
    if (!h_rstn) begin
      state   <= IDLE;
      shadow  <= '0;
      occ     <= '0;
      cur_lvl <= '0;
      trigger <= 1'b0;
    end else if (disarm) begin
      state   <= IDLE;
      occ     <= '0;
      cur_lvl <= '0;
      trigger <= 1'b0;
    end else if (arm) begin
      state   <= ARMED;
      shadow  <= chain;
      occ     <= '0;
      cur_lvl <= '0;
      trigger <= 1'b0;
    end else begin
      case (state)
        ARMED: begin
          if (hit) begin
            if (occ == cur_cnt) begin
              if (cur_lvl == last_lvl) begin
                state   <= TRIGGERED;
                trigger <= 1'b1;
              end else begin
                cur_lvl <= cur_lvl + LVL_W'(1);
                occ     <= '0;
              end
            end else begin
              occ <= occ + CNT_WIDTH'(1);
            end
          end
        end
        TRIGGERED: begin
`ifdef IPS_DBC_TRIG_LEVEL_EN
          trigger <= 1'b1;
`else
          trigger <= 1'b0;
`endif
        end
        default: begin
          trigger <= 1'b0;
        end
      endcase
    end
  end

  assign seq_state = state;

endmodule

// File: tb/tb_ips_dbc_trigger_seq_v1_2.sv
// Directed plus randomized bench for ips_dbc_trigger_seq_v1_2 against a hit-counting reference model.
module tb_ips_dbc_trigger_seq_v1_2;

  logic       clk_trig = 1'b0;
  logic       h_rstn;
  logic [3:0] match;
  logic       conf_sel, shift_i, conf_tdi, arm, disarm;
  logic       conf_tdo, trigger;
  logic [1:0] seq_state;
  logic [1:0] cur_lvl;

  ips_dbc_trigger_seq_v1_2 dut (
    .clk_trig (clk_trig),
    .h_rstn   (h_rstn),
    .match    (match),
    .conf_sel (conf_sel),
    .shift_i  (shift_i),
    .conf_tdi (conf_tdi),
    .conf_tdo (conf_tdo),
    .arm      (arm),
    .disarm   (disarm),
    .trigger  (trigger),
    .seq_state(seq_state),
    .cur_lvl  (cur_lvl)
  );

  always #5 clk_trig = ~clk_trig;

  // reference model: configuration kept as decoded arrays, progress as hits seen on the current level
  logic [41:0] m_chain;
  int          m_sel [4];
  int          m_cnt [4];
  int          m_last;
  int          m_state, m_lvl, m_hits;
  logic        m_trig;

  int n_total = 0;
  int n_pass  = 0;

  logic [41:0] pat;
  logic [41:0] cfg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, got, exp, $time);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":trigger"}, 32'(trigger), 32'(m_trig));
    chk({tag, ":seq_state"}, 32'(seq_state), 32'(m_state));
    chk({tag, ":cur_lvl"}, 32'(cur_lvl), 32'(m_lvl));
    chk({tag, ":conf_tdo"}, 32'(conf_tdo), 32'(m_chain[0]));
  endtask

  task automatic model_reset();
    m_chain = '0;
    for (int k = 0; k < 4; k++) begin m_sel[k] = 0; m_cnt[k] = 0; end
    m_last = 0; m_state = 0; m_lvl = 0; m_hits = 0; m_trig = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] m, input logic a, input logic d,
                            input logic sh, input logic tdi);
    logic [41:0] old_chain;
    old_chain = m_chain;
    if (sh) m_chain = {tdi, m_chain[41:1]};
    if (d) begin
      m_state = 0; m_lvl = 0; m_hits = 0; m_trig = 1'b0;
    end else if (a) begin
      for (int k = 0; k < 4; k++) begin
        m_cnt[k] = int'(old_chain[k*10 +: 8]);
        m_sel[k] = int'(old_chain[k*10 + 8 +: 2]);
      end
      m_last  = int'(old_chain[41:40]);
      m_state = 1; m_lvl = 0; m_hits = 0; m_trig = 1'b0;
    end else if (m_state == 1) begin
      if (m[m_sel[m_lvl]]) begin
        m_hits++;
        if (m_hits == m_cnt[m_lvl] + 1) begin
          if (m_lvl == m_last) begin
            m_state = 2; m_trig = 1'b1;
          end else begin
            m_lvl++; m_hits = 0;
          end
        end
      end
    end else if (m_state == 2) begin
`ifdef IPS_DBC_TRIG_LEVEL_EN
      m_trig = 1'b1;
`else
      m_trig = 1'b0;
`endif
    end
  endtask

  task automatic step(input string tag, input logic [3:0] m, input logic a, input logic d,
                      input logic sh, input logic tdi);
    @(negedge clk_trig);
    match = m; arm = a; disarm = d; conf_sel = sh; shift_i = sh; conf_tdi = tdi;
    @(posedge clk_trig);
    model_edge(m, a, d, sh, tdi);
    #1;
    check_all(tag);
  endtask

  task automatic idle_cycle(input string tag);
    step(tag, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [41:0] make_cfg(input int last, input int s0, input int c0,
                                           input int s1, input int c1, input int s2,
                                           input int c2, input int s3, input int c3);
    logic [41:0] v;
    v = '0;
    v[41:40] = 2'(last);
    v[9:0]   = {2'(s0), 8'(c0)};
    v[19:10] = {2'(s1), 8'(c1)};
    v[29:20] = {2'(s2), 8'(c2)};
    v[39:30] = {2'(s3), 8'(c3)};
    return v;
  endfunction

  task automatic load_cfg(input logic [41:0] v);
    for (int i = 0; i < 42; i++) step("shift", 4'b0000, 1'b0, 1'b0, 1'b1, v[i]);
  endtask

  task automatic do_reset();
    @(negedge clk_trig);
    h_rstn = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk_trig);
    h_rstn = 1'b1;
  endtask

  initial begin
    match = '0; arm = 0; disarm = 0; conf_sel = 0; shift_i = 0; conf_tdi = 0;
    h_rstn = 1'b1;
    model_reset();
    #3 h_rstn = 1'b0;
    #10;
    check_all("reset_init");
    do_reset();

    // readback: second pass of shifts replays the first 42 bits LSB first
    pat = 42'h2AA_AAAA_AAAA;
    for (int i = 0; i < 42; i++) step("rb_load", 4'b0000, 1'b0, 1'b0, 1'b1, pat[i]);
    for (int i = 0; i < 42; i++) begin
      chk("rb_tdo_direct", 32'(conf_tdo), 32'(pat[i]));
      step("rb_replay", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("rb_idle_state", 32'(seq_state), 32'd0);
    end

    // single level, sel 2, cnt 3: four hits, noise on other bits
    load_cfg(make_cfg(0, 2, 3, 0, 0, 0, 0, 0, 0));
    step("sl_arm", 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int h = 0; h < 4; h++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++)
        step("sl_gap", 4'($urandom) & 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
      step("sl_hit", 4'b0100 | (4'($urandom) & 4'b1011), 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sl_trig_after_hit", 32'(trigger), (h == 3) ? 32'd1 : 32'd0);
    end
    idle_cycle("sl_hold");

    // three-level sequence with back-to-back advances
    load_cfg(make_cfg(2, 0, 0, 1, 0, 3, 0, 0, 0));
    step("tl_arm", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    step("tl_s0", 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tl_lvl1", 32'(cur_lvl), 32'd1);
    step("tl_s1", 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tl_ignored", 32'(cur_lvl), 32'd1);
    step("tl_s2", 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tl_lvl2", 32'(cur_lvl), 32'd2);
    step("tl_s3", 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tl_fire", 32'(trigger), 32'd1);
    idle_cycle("tl_hold");
    idle_cycle("tl_hold2");

    // arm while TRIGGERED restarts; arm+disarm while ARMED goes IDLE
    step("cp_rearm", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("cp_rearm_state", 32'(seq_state), 32'd1);
    chk("cp_rearm_trig", 32'(trigger), 32'd0);
    step("cp_s0", 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    step("cp_both", 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("cp_both_state", 32'(seq_state), 32'd0);
    step("cp_idle_match", 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);

    // shadow isolation: reshift while armed must not change the running count
    load_cfg(make_cfg(0, 0, 1, 0, 0, 0, 0, 0, 0));
    step("sh_arm", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    load_cfg(make_cfg(0, 0, 5, 0, 0, 0, 0, 0, 0));
    step("sh_hit1", 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    step("sh_hit2", 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sh_fire", 32'(seq_state), 32'd2);

    // reset mid-sequence at level 1 with two hits counted
    load_cfg(make_cfg(2, 0, 0, 1, 5, 2, 0, 0, 0));
    step("rm_arm", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    step("rm_l0", 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rm_o1", 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rm_o2", 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_trig);
    #2 h_rstn = 1'b0;
    model_reset();
    #1;
    check_all("rm_async");
    @(negedge clk_trig);
    h_rstn = 1'b1;
    for (int i = 0; i < 4; i++) step("rm_after", 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);

    // randomized: random configs, random arm/disarm/match/shift traffic
    for (int r = 0; r < 6; r++) begin
      cfg = {$urandom, $urandom};
      for (int k = 0; k < 4; k++) cfg[k*10 +: 8] = 8'($urandom_range(0, 3));
      load_cfg(cfg);
      step("rnd_arm", 4'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 60; c++) begin
        int p;
        p = $urandom_range(0, 99);
        step("rnd", 4'($urandom), p < 3, p == 3, p > 90, 1'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
